// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
// Holds the IDLE/BUSY state encoding used by the sequencer.
package mux_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Bundle between requesters, the arbiter and the shared sink.
// master: drives req/data_in, observes grant and muxed output.
// slave : the arbiter; samples req/data_in, drives gnt, sel,
//         busy, out_valid and out_data.
interface mux_rr_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    gnt;
    logic [SW-1:0]   sel;
    logic            busy;
    logic            out_valid;
    logic [DW-1:0]   out_data;

    modport master (
        output req, data_in,
        input  gnt, sel, busy, out_valid, out_data
    );

    modport slave (
        input  req, data_in,
        output gnt, sel, busy, out_valid, out_data
    );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick_first.sv
// Rotating first-set-bit finder: scans mask from start upward,
// modulo N. Ports: mask, start in; found, idx out (combinational).
module mux_rr_arbiter_rr_pick_first #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [SW-1:0] start,
    output logic          found,
    output logic [SW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SW-1:0]  off;
    logic [SW:0]    sum;

    // rot[k] = mask[(start + k) mod N]
    assign dbl = {mask, mask};
    assign rot = dbl[start +: N];

    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = SW'(k);
            end
        end
    end

    // Un-rotate the offset back to an absolute index.
    assign found = |rot;
    assign sum   = {1'b0, start} + {1'b0, off};
    assign idx   = (sum >= (SW+1)'(N)) ? SW'(sum - (SW+1)'(N))
                                       : SW'(sum);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one N:1 mux tree among N requesters.
// Ports: clk, rst_n (async low); bus (slave) carries req, data_in,
//        gnt, sel, busy, out_valid, out_data.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int NP = 1 << SW;

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [N-1:0]  cand;
    logic          found;
    logic [SW-1:0] pick;
    logic [SW-1:0] pick_inc;

    // While busy the current grantee is masked out; on release
    // its req bit is already zero, so one mask serves both cases.
    assign cand = (state_q == BUSY)
                ? (bus.req & ~(N'(1) << sel_q))
                : bus.req;

    mux_rr_arbiter_rr_pick_first #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .mask  (cand),
        .start (ptr_q),
        .found (found),
        .idx   (pick)
    );

    assign pick_inc = (pick == SW'(N - 1)) ? '0 : pick + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    gnt_d   = N'(1) << pick;
                    sel_d   = pick;
                    ptr_d   = pick_inc;
                    hold_d  = HW'(1);
                end
            end
            BUSY: begin
                if (!bus.req[sel_q] || hold_q == HW'(MAX_HOLD)) begin
                    if (found) begin
                        gnt_d  = N'(1) << pick;
                        sel_d  = pick;
                        ptr_d  = pick_inc;
                        hold_d = HW'(1);
                    end else if (!bus.req[sel_q]) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Binary tree of 2:1 muxes in heap order; node i has
    // children 2i+1 and 2i+2, root steered by the sel MSB.
    logic [DW-1:0] node [2*NP-1];

    for (genvar i = 0; i < NP - 1; i++) begin : g_node
        localparam int D = $clog2(i + 2) - 1;
        assign node[i] = sel_q[SW-1-D] ? node[2*i+2]
                                       : node[2*i+1];
    end

    for (genvar i = 0; i < NP; i++) begin : g_leaf
        if (i < N) begin : g_used
            assign node[NP-1+i] = bus.data_in[i*DW +: DW];
        end else begin : g_pad
            assign node[NP-1+i] = '0;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == BUSY);
    assign bus.out_valid = bus.busy & bus.req[sel_q];
    assign bus.out_data  = bus.out_valid ? node[0] : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (N=4, DW=8, MAX_HOLD=4).
// Directed scenarios plus randomized traffic against a reference model.
module tb_mux_rr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int MH    = 4;
    localparam int LIMIT = (N - 1) * MH + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.N(N), .DW(DW)) bus ();

    mux_rr_arbiter #(
        .N        (N),
        .DW       (DW),
        .MAX_HOLD (MH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // reference model state
    int m_busy, m_s, m_ptr, m_hold;

    function automatic logic [7:0] dat(input int i);
        return 8'(160 + 17 * i);
    endfunction

    function automatic int pick(input logic [3:0] m, input int p);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    task automatic m_grant(input int p);
        m_busy = 1;
        m_s    = p;
        m_hold = 1;
        m_ptr  = (p + 1) % N;
    endtask

    task automatic model_step(input logic [3:0] r);
        int p;
        if (m_busy == 0) begin
            p = pick(r, m_ptr);
            if (p >= 0) m_grant(p);
        end else if (!r[m_s]) begin
            p = pick(r, m_ptr);
            if (p >= 0) m_grant(p);
            else m_busy = 0;
        end else if (m_hold < MH) begin
            m_hold++;
        end else begin
            p = pick(r & ~(4'b0001 << m_s), m_ptr);
            if (p >= 0) m_grant(p);
        end
    endtask

    task automatic cyc(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        #1;
        total++;
        if (bus.gnt !== 4'b0000) begin
            bad++;
            $display("FAIL reset_gnt: got %b want 0000", bus.gnt);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %b want 0", bus.out_valid);
        end
        total++;
        if (bus.out_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: got %h want 00", bus.out_data);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0
            || bus.out_valid !== 1'b0 || bus.sel !== 2'd0) begin
            bad++;
            $display("FAIL reset_hold: got gnt=%b busy=%b valid=%b sel=%0d want 0000/0/0/0",
                     bus.gnt, bus.busy, bus.out_valid, bus.sel);
        end
        bus.req = '0;
        rst_n   = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        cyc(4'b0100);
        total++;
        if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2) begin
            bad++;
            $display("FAIL single_gnt: got gnt=%b sel=%0d want 0100/2",
                     bus.gnt, bus.sel);
        end
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC2) begin
            bad++;
            $display("FAIL single_data: got valid=%b data=%h want 1/c2",
                     bus.out_valid, bus.out_data);
        end
        cyc(4'b0100);
        cyc(4'b0100);
        cyc(4'b0000);
        total++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0
            || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drop: got gnt=%b busy=%b valid=%b want 0000/0/0",
                     bus.gnt, bus.busy, bus.out_valid);
        end
        total++;
        if (bus.sel !== 2'd2) begin
            bad++;
            $display("FAIL single_sel_kept: got %0d want 2", bus.sel);
        end
    endtask

    task automatic test_regrant();
        do_reset();
        cyc(4'b1111);
        total++;
        if (bus.gnt !== 4'b0001 || bus.out_data !== 8'hA0) begin
            bad++;
            $display("FAIL regrant_first: got gnt=%b data=%h want 0001/a0",
                     bus.gnt, bus.out_data);
        end
        cyc(4'b1111);
        bus.req = 4'b1110;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            bad++;
            $display("FAIL regrant_comb_drop: got valid=%b data=%h want 0/00",
                     bus.out_valid, bus.out_data);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.gnt !== 4'b0010 || bus.out_data !== 8'hB1) begin
            bad++;
            $display("FAIL regrant_next: got gnt=%b data=%h want 0010/b1",
                     bus.gnt, bus.out_data);
        end
    endtask

    task automatic test_hold_cap();
        logic [3:0] exp;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            cyc(4'b0011);
            exp = (((i - 1) / MH) % 2 == 1) ? 4'b0010 : 4'b0001;
            total++;
            if (bus.gnt !== exp) begin
                bad++;
                $display("FAIL hold_cap[%0d]: got %b want %b",
                         i, bus.gnt, exp);
            end
        end
    endtask

    task automatic test_sat_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0001);
            total++;
            if (bus.gnt !== 4'b0001) begin
                bad++;
                $display("FAIL sat[%0d]: got %b want 0001", i, bus.gnt);
            end
        end
        cyc(4'b1001);
        total++;
        if (bus.gnt !== 4'b1000 || bus.out_data !== 8'hD3) begin
            bad++;
            $display("FAIL wrap_rotate: got gnt=%b data=%h want 1000/d3",
                     bus.gnt, bus.out_data);
        end
        for (int i = 2; i <= MH; i++) begin
            cyc(4'b1001);
            total++;
            if (bus.gnt !== 4'b1000) begin
                bad++;
                $display("FAIL wrap_hold[%0d]: got %b want 1000",
                         i, bus.gnt);
            end
        end
        cyc(4'b1001);
        total++;
        if (bus.gnt !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_back: got %b want 0001", bus.gnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(4'b0100);
        total++;
        if (bus.gnt !== 4'b0100) begin
            bad++;
            $display("FAIL arst_pre: got %b want 0100", bus.gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.gnt !== 4'b0000 || bus.out_valid !== 1'b0
            || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL arst_drop: got gnt=%b valid=%b busy=%b want 0000/0/0",
                     bus.gnt, bus.out_valid, bus.busy);
        end
        bus.req = 4'b1010;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'b1010);
        total++;
        if (bus.gnt !== 4'b0010 || bus.sel !== 2'd1) begin
            bad++;
            $display("FAIL arst_restart: got gnt=%b sel=%0d want 0010/1",
                     bus.gnt, bus.sel);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] eg;
        logic       ev;
        logic [7:0] ed;
        int         w [N];
        do_reset();
        m_busy = 0;
        m_s    = 0;
        m_ptr  = 0;
        m_hold = 0;
        r      = '0;
        for (int i = 0; i < N; i++) w[i] = 0;
        for (int c = 0; c < 500; c++) begin
            r = r ^ (4'($urandom) & 4'($urandom));
            cyc(r);
            model_step(r);
            eg = (m_busy != 0) ? 4'(4'b0001 << m_s) : 4'b0000;
            ev = (m_busy != 0) && r[m_s];
            ed = ev ? dat(m_s) : 8'h00;
            total++;
            if (bus.gnt !== eg || bus.sel !== 2'(m_s)
                || bus.busy !== (m_busy != 0)) begin
                bad++;
                $display("FAIL rnd_gnt[%0d]: got gnt=%b sel=%0d busy=%b want %b/%0d/%0d",
                         c, bus.gnt, bus.sel, bus.busy, eg, m_s, m_busy);
            end
            total++;
            if (bus.out_valid !== ev || bus.out_data !== ed) begin
                bad++;
                $display("FAIL rnd_out[%0d]: got valid=%b data=%h want %b/%h",
                         c, bus.out_valid, bus.out_data, ev, ed);
            end
            for (int i = 0; i < N; i++) begin
                if (r[i] && !bus.gnt[i]) w[i]++;
                else w[i] = 0;
                if (r[i]) begin
                    total++;
                    if (w[i] > LIMIT) begin
                        bad++;
                        $display("FAIL rnd_starve[%0d] req%0d: got wait=%0d want <=%0d",
                                 c, i, w[i], LIMIT);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.data_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        bus.req     = '0;
        rst_n       = 1'b0;
        test_reset();
        test_single();
        test_regrant();
        test_hold_cap();
        test_sat_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
